viterbi_decoder_param: RTL and testbench
========================================

# viterbi_decoder_param

Parametrised soft-decision Viterbi decoder for the IEEE 802.11a convolutional code: K=7, generators A=133₈ and B=171₈. It depunctures rates 1/2, 2/3 and 3/4 internally and accepts a configurable soft-bit width and maximum frame length. It is tail-terminated and block-based: the whole frame is decoded, then traced back from state 0, then streamed out in order. It sits after the deinterleaver and feeds the descrambler in the receive chain, replacing the fixed-length, hard-decision, rate-1/2 decoder.

## Interface
- SOFT_W, 3, width of a received soft coded bit; unsigned, 0 = strong "0", 2^SOFT_W−1 = strong "1".
- MAX_LEN, 1024, maximum decoded bits per frame, tail included.
- LEN_W, 11, Length width; at least clog2(MAX_LEN+1).
- PM_W, 10, path-metric width; at least SOFT_W+6.

- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  frame start; sampled in IDLE only.
- Rate  in  2  sampled with Start: 0 = 1/2, 1 = 2/3, 2 = 3/4, 3 = invalid.
- Length  in  LEN_W  decoded bits L in the frame, tail included; sampled with Start.
- x  in  SOFT_W  received soft coded bit.
- In_Valid  in  1  x is valid.
- In_Ready  out  1  decoder accepts x; high in RECV only.
- Out  out  1  decoded bit.
- Valid  out  1  Out is valid.
- Done  out  1  one-cycle pulse coincident with the last Valid bit.
- Err  out  1  one-cycle pulse when frame parameters are rejected.
- Busy  out  1  high in every state except IDLE.

## Operation
- States and transitions:
  - IDLE → RECV on Start, when parameters are valid.
  - IDLE → IDLE with an Err pulse on Start, when parameters are invalid.
  - RECV → TRACE after the L-th trellis step.
  - TRACE → OUT after L cycles.
  - OUT → IDLE after L cycles.
- Parameters are invalid when any of these holds:
  - Rate = 3;
  - L < 7 or L > MAX_LEN;
  - Rate 2/3 and L odd;
  - Rate 3/4 and L not a multiple of 3.
- Start outside IDLE is ignored.
- Symbol acceptance: a symbol is accepted on In_Valid && In_Ready. In_Valid gaps stall RECV with no other effect.
- Received bit order is A0, B0, A1, B1, … with stolen bits omitted:
  - 2/3: per 2 steps, A0 B0 A1 are received; B1 is stolen.
  - 3/4: per 3 steps, A0 B0 A1 B2 are received; B1 and A2 are stolen.
  - Received bits per frame: 2L, 3L/2 or 4L/3.
- State convention:
  - s[5] is the newest input bit.
  - next state = {u, s[5:1]}.
  - A = u⊕s[4]⊕s[3]⊕s[1]⊕s[0]; B = u⊕s[5]⊕s[4]⊕s[3]⊕s[0].
- Branch metric, per received coded bit c against hypothesis h:
  - h=0 costs x; h=1 costs (2^SOFT_W−1)−x.
  - A stolen bit costs 0.
  - The step metric is the sum over A and B.
- ACS:
  - All 64 states update in one cycle, the cycle the step's last received bit is accepted.
  - Predecessors of state t are {t[4:0],0} and {t[4:0],1}.
  - The smaller candidate wins; on a tie, the predecessor with LSB 0 wins.
  - The one-bit decision per state is stored in survivor memory (MAX_LEN×64) at the step index.
- Metric arithmetic:
  - Metrics are modulo 2^PM_W.
  - a<b is decided by the MSB of (a−b) mod 2^PM_W.
  - Initial metrics: state 0 = 0, all other states = 2^(PM_W−2).
- TRACE:
  - Starts from state 0 at step L−1, one step per cycle.
  - Decoded bit = s[5] of the current state.
  - Previous state = {s[4:0], decision}.
  - Bits are written to an L-bit output buffer at index L−1 down to 0.
- OUT streams buffer bits 0 to L−1, including the 6 tail bits, with no backpressure.

## Timing
- Reset values: Out, Valid, Done, Err, Busy and In_Ready are all 0, and the state is IDLE.
- Reset asserted in any state aborts the frame immediately; no partial output is produced.
- Cycle after Start (valid parameters): Busy=1 and In_Ready=1.
- Cycle after Start (invalid parameters): Err=1 for 1 cycle; Busy, In_Ready and Valid stay 0.
- Cycle after the last accepted symbol: In_Ready=0 and the first TRACE cycle begins.
- First Valid: L+1 cycles after the last accept edge.
- Valid is high for exactly L consecutive cycles; Done accompanies bit L−1.
- IDLE is entered the cycle after Done; Start is accepted that same cycle.
- Throughput at continuous In_Valid: a frame occupies (received bits)+2L+1 cycles.

## Test plan
- Rate 1/2, L=276, random data plus 6 zero tail, hard soft values (0/7), In_Valid continuous:
  - 552 inputs accepted; 276 Valid bits equal the source; Done once; first Valid 277 cycles after last accept.
- Rate 3/4, L=48, clean punctured stream:
  - 64 inputs accepted; output matches source.
- Rate 2/3, L=48:
  - 72 inputs accepted; output matches source.
- Rate 1/2, L=96, 4 isolated coded-bit inversions ≥20 bits apart, plus soft values of 3/4 on 10 bits:
  - zero output errors.
- Invalid parameters, each followed by a valid frame that must decode correctly:
  - Rate=1 with L=25 → Err pulse, Busy and In_Ready stay 0, no Valid.
  - Rate=3 → Err pulse.
  - L=MAX_LEN+1 → Err pulse.
- Reset pulsed mid-RECV and again mid-OUT:
  - all outputs 0 next cycle.
  - a following rate 1/2 L=24 frame decodes correctly.
- Random In_Valid throttling (50%), plus Start pulsed during RECV:
  - output is identical to the unthrottled run.
  - the mid-RECV Start is ignored.

Source files
------------

// File: rtl/viterbi_decoder_param.sv
// Block soft-decision Viterbi decoder, K=7 (133/171), depuncturing 1/2, 2/3, 3/4.
// The whole frame is decoded, traced back from state 0, then streamed out.
module viterbi_decoder_param #(
  parameter int SOFT_W  = 3,
  parameter int MAX_LEN = 1024,
  parameter int LEN_W   = 11,
  parameter int PM_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        rate_i,
  input  logic [LEN_W-1:0]  length_i,
  input  logic [SOFT_W-1:0] x_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              out_o,
  output logic              valid_o,
  output logic              done_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [SOFT_W-1:0] SMAX = '1;
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(1) << (PM_W - 2);
  localparam logic [LEN_W-1:0] L_ONE = LEN_W'(1);

  typedef enum logic [1:0] {IDLE, RECV, TRACE, OUT} state_e;

  state_e            state_q;
  logic [1:0]        rate_q;
  logic [1:0]        ph_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  step_q;
  logic [LEN_W-1:0]  idx_q;
  logic [LEN_W-1:0]  oc_q;
  logic              hb_q;
  logic [SOFT_W-1:0] a_q;
  logic [PM_W-1:0]   pm_q [64];
  logic [5:0]        tst_q;
  logic              rdy_q;
  logic              out_q;
  logic              valid_q;
  logic              done_q;
  logic              err_q;
  logic              busy_q;

  logic [63:0]        surv_q [MAX_LEN];
  logic [MAX_LEN-1:0] obuf_q;

  logic              need_a;
  logic              need_b;
  logic              is_b;
  logic              acc;
  logic              step_done;
  logic              params_ok;
  logic              surv_bit;
  logic [1:0]        ph_nxt;
  logic [SOFT_W-1:0] sa;
  logic [SOFT_W:0]   bm [4];
  logic [PM_W-1:0]   c0 [64];
  logic [PM_W-1:0]   c1 [64];
  logic [PM_W-1:0]   pm_d [64];
  logic [63:0]       dec_d;

  function automatic logic [SOFT_W:0] cost(
    input logic [SOFT_W-1:0] s,
    input logic              h,
    input logic              en
  );
    if (!en) return '0;
    return h ? {1'b0, SMAX - s} : {1'b0, s};
  endfunction

  function automatic logic [1:0] enc(
    input logic [5:0] p,
    input logic       u
  );
    return {u ^ p[4] ^ p[3] ^ p[1] ^ p[0],
            u ^ p[5] ^ p[4] ^ p[3] ^ p[0]};
  endfunction

  function automatic logic lt(
    input logic [PM_W-1:0] a,
    input logic [PM_W-1:0] b
  );
    logic [PM_W-1:0] d;
    d = a - b;
    return d[PM_W-1];
  endfunction

  assign params_ok = (rate_i != 2'd3)
                  && (length_i >= LEN_W'(7))
                  && (length_i <= LEN_W'(MAX_LEN))
                  && !(rate_i == 2'd1 && length_i[0])
                  && !(rate_i == 2'd2
                       && (length_i % LEN_W'(3)) != '0);

  // ph_q cycles 0..rate_q, which is exactly the puncturing period
  assign need_a    = !(rate_q == 2'd2 && ph_q == 2'd2);
  assign need_b    = !(ph_q == 2'd1 && rate_q != 2'd0);
  assign is_b      = hb_q || !need_a;
  assign acc       = rdy_q && in_valid_i;
  assign step_done = acc && (is_b || !need_b);
  assign sa        = is_b ? a_q : x_i;
  assign ph_nxt    = (ph_q == rate_q) ? 2'd0 : ph_q + 2'd1;
  assign surv_bit  = surv_q[idx_q[AW-1:0]][tst_q];

  always_comb begin
    for (int h = 0; h < 4; h++) begin
      bm[h] = cost(sa, h[1], need_a) + cost(x_i, h[0], need_b);
    end
    for (int t = 0; t < 64; t++) begin
      c0[t] = pm_q[6'(2*t)]
            + PM_W'(bm[enc(6'(2*t), t[5])]);
      c1[t] = pm_q[6'(2*t+1)]
            + PM_W'(bm[enc(6'(2*t+1), t[5])]);
      dec_d[t] = lt(c1[t], c0[t]);
      pm_d[t]  = dec_d[t] ? c1[t] : c0[t];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rate_q  <= '0;
      ph_q    <= '0;
      len_q   <= '0;
      step_q  <= '0;
      idx_q   <= '0;
      oc_q    <= '0;
      hb_q    <= 1'b0;
      a_q     <= '0;
      tst_q   <= '0;
      rdy_q   <= 1'b0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < 64; i++) pm_q[i] <= '0;
    end else begin
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: if (start_i) begin
          if (params_ok) begin
            state_q <= RECV;
            rate_q  <= rate_i;
            len_q   <= length_i;
            step_q  <= '0;
            ph_q    <= '0;
            hb_q    <= 1'b0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b1;
            for (int i = 0; i < 64; i++)
              pm_q[i] <= (i == 0) ? '0 : PM_INIT;
          end else begin
            err_q <= 1'b1;
          end
        end
        RECV: if (acc) begin
          if (step_done) begin
            for (int i = 0; i < 64; i++) pm_q[i] <= pm_d[i];
            hb_q   <= 1'b0;
            ph_q   <= ph_nxt;
            step_q <= step_q + L_ONE;
            if (step_q == len_q - L_ONE) begin
              state_q <= TRACE;
              rdy_q   <= 1'b0;
              idx_q   <= len_q - L_ONE;
              tst_q   <= '0;
            end
          end else begin
            a_q  <= x_i;
            hb_q <= 1'b1;
          end
        end
        TRACE: begin
          tst_q <= {tst_q[4:0], surv_bit};
          idx_q <= idx_q - L_ONE;
          if (idx_q == '0) begin
            state_q <= OUT;
            oc_q    <= '0;
          end
        end
        OUT: begin
          out_q   <= obuf_q[oc_q[AW-1:0]];
          valid_q <= 1'b1;
          oc_q    <= oc_q + L_ONE;
          if (oc_q == len_q - L_ONE) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (step_done) surv_q[step_q[AW-1:0]] <= dec_d;
    if (state_q == TRACE) obuf_q[idx_q[AW-1:0]] <= tst_q[5];
  end

  assign in_ready_o = rdy_q;
  assign out_o      = out_q;
  assign valid_o    = valid_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_viterbi_decoder_param.sv
// Directed bench for viterbi_decoder_param: encoder model drives frames,
// decoded stream is compared with the source bits.
module tb_viterbi_decoder_param;

  localparam int SW = 3;
  localparam int ML = 1024;
  localparam int LW = 11;
  localparam int PW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    rate = '0;
  logic [LW-1:0] len = '0;
  logic [SW-1:0] x = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          dout;
  logic          valid;
  logic          done;
  logic          err;
  logic          busy;

  always #5 clk = ~clk;

  viterbi_decoder_param #(
    .SOFT_W(SW), .MAX_LEN(ML), .LEN_W(LW), .PM_W(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .rate_i(rate), .length_i(len), .x_i(x),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_o(dout), .valid_o(valid), .done_o(done),
    .err_o(err), .busy_o(busy)
  );

  typedef struct {
    int rate;
    int len;
    int n_in;
    bit noise;
    int thr;
    bit mid;
    bit reuse;
  } vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit src [ML];
  bit obits [ML];
  bit prev [ML];
  int coded [$];
  int ocnt = 0;
  int first_cyc = -1;
  int done_idx = -1;
  int dones = 0;
  int errs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      if (ocnt < ML) obits[ocnt] = dout;
      if (ocnt == 0) first_cyc = cyc;
      ocnt++;
      if (done) begin
        dones++;
        done_idx = ocnt;
      end
    end
    if (err) errs++;
  end

  task automatic check(input string nm, input longint act,
                       input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic gen(input vec_t v);
    logic [5:0] s;
    logic a, b, u;
    int ph, p;
    int flips [4] = '{5, 45, 95, 145};
    coded.delete();
    s = '0;
    for (int i = 0; i < v.len; i++) begin
      if (!v.reuse)
        src[i] = (i < v.len - 6) ? 1'($urandom) : 1'b0;
      u = src[i];
      a = u ^ s[4] ^ s[3] ^ s[1] ^ s[0];
      b = u ^ s[5] ^ s[4] ^ s[3] ^ s[0];
      s = {u, s[5:1]};
      ph = i % (v.rate + 1);
      if (!(v.rate == 2 && ph == 2)) coded.push_back(a ? 7 : 0);
      if (!(v.rate > 0 && ph == 1)) coded.push_back(b ? 7 : 0);
    end
    if (v.noise) begin
      foreach (flips[k]) coded[flips[k]] = 7 - coded[flips[k]];
      for (int k = 0; k < 10; k++) begin
        p = 20 + 10 * k;
        coded[p] = (coded[p] != 0) ? 4 : 3;
      end
    end
  endtask

  task automatic start_frame(input int r, input int l);
    rate = 2'(r);
    len = LW'(l);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int upto, input int thr, input bit mid,
                      output int acc_n, output int last_edge);
    int idx, guard;
    bit pulsed;
    idx = 0; guard = 0; acc_n = 0; last_edge = 0; pulsed = 0;
    while (idx < upto && guard < 8 * upto + 100) begin
      in_valid = (thr == 0) || ($urandom_range(99) >= thr);
      x = SW'(coded[idx]);
      start = 1'b0;
      if (mid && !pulsed && idx == upto / 2) begin
        start = 1'b1; rate = 2'd0; len = LW'(7); pulsed = 1;
      end
      if (in_valid && in_ready) begin
        acc_n++;
        idx++;
        last_edge = cyc + 1;
      end
      guard++;
      @(negedge clk);
    end
    start = 1'b0;
    check("feed_count", idx, upto);
  endtask

  task automatic run_frame(input vec_t v);
    int acc_n, last_edge, extra, guard, nerr, ndiff;
    gen(v);
    ocnt = 0; dones = 0; errs = 0; done_idx = -1; first_cyc = -1;
    start_frame(v.rate, v.len);
    check("start_busy", busy, 1);
    check("start_ready", in_ready, 1);
    feed(coded.size(), v.thr, v.mid, acc_n, last_edge);
    check("ready_drop", in_ready, 0);
    in_valid = 1'b1; x = '0; extra = 0; guard = 0;
    while (!done && guard < 3 * v.len + 20) begin
      if (in_ready) extra++;
      guard++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("done_seen", done, 1);
    @(negedge clk);
    check("idle_after", {busy, valid}, 0);
    nerr = 0;
    for (int i = 0; i < v.len; i++) if (obits[i] != src[i]) nerr++;
    check("accepted", acc_n + extra, v.n_in);
    check("n_valid", ocnt, v.len);
    check("n_done", dones, 1);
    check("done_pos", done_idx, v.len);
    check("latency", first_cyc - last_edge, v.len + 1);
    check("bit_errs", nerr, 0);
    check("no_err", errs, 0);
    if (v.reuse) begin
      ndiff = 0;
      for (int i = 0; i < v.len; i++) if (obits[i] != prev[i]) ndiff++;
      check("same_as_prev", ndiff, 0);
    end
    for (int i = 0; i < v.len; i++) prev[i] = obits[i];
  endtask

  task automatic bad_params(input int r, input int l);
    ocnt = 0;
    start_frame(r, l);
    check("err_pulse", err, 1);
    check("err_quiet", {busy, in_ready, valid}, 0);
    @(negedge clk);
    check("err_once", err, 0);
    check("err_idle", {busy, in_ready, valid}, 0);
    check("err_novalid", ocnt, 0);
  endtask

  vec_t tbl [6];
  vec_t f24;

  initial begin
    int acc_n, last_edge, guard, n0;
    tbl[0] = '{0, 276, 552, 0, 0, 0, 0};
    tbl[1] = '{2, 48, 64, 0, 0, 0, 0};
    tbl[2] = '{1, 48, 72, 0, 0, 0, 0};
    tbl[3] = '{0, 96, 192, 1, 0, 0, 0};
    tbl[4] = '{2, 48, 64, 0, 0, 0, 0};
    tbl[5] = '{2, 48, 64, 0, 50, 1, 1};
    f24 = '{0, 24, 48, 0, 0, 0, 0};

    repeat (3) @(negedge clk);
    check("reset_outs", {dout, valid, done, err, busy, in_ready}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_frame(tbl[i]);

    bad_params(1, 25);
    run_frame('{1, 24, 36, 0, 0, 0, 0});
    bad_params(3, 24);
    run_frame('{2, 24, 32, 0, 0, 0, 0});
    bad_params(0, ML + 1);
    run_frame('{0, 30, 60, 0, 0, 0, 0});
    bad_params(0, 6);
    bad_params(2, 25);
    run_frame(f24);

    // abort mid-receive
    gen(f24);
    ocnt = 0;
    start_frame(0, 24);
    feed(10, 0, 0, acc_n, last_edge);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_recv", {dout, valid, done, err, busy, in_ready}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // abort mid-output
    gen(f24);
    ocnt = 0;
    start_frame(0, 24);
    feed(coded.size(), 0, 0, acc_n, last_edge);
    in_valid = 1'b0;
    guard = 0;
    while (ocnt < 5 && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    check("out_reached", ocnt >= 5, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_out", {dout, valid, done, err, busy, in_ready}, 0);
    n0 = ocnt;
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("no_partial", ocnt, n0);

    run_frame(f24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
